// File: rtl/a09_defs.sv
// rtl/a09_defs.sv - shared state encodings and strobe levels for the A09 fetch path
//
// Purpose: common definitions imported by the fetch sequencer and its program
// counter. Holds the 3-bit binary FSM encoding, the active-low load strobe
// levels and a helper that sizes the memory-wait counter.
// Ports: none (package).

package a09_defs;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_FETCH = 3'd1,
        S_MEMRD = 3'd2,
        S_IRLD  = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    localparam logic LD_ACTIVE = 1'b0;
    localparam logic LD_IDLE   = 1'b1;

    // Wait counter must hold 0..timeout; never narrower than one bit.
    function automatic int wait_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/a09_fetch_sequencer_if.sv
// rtl/a09_fetch_sequencer_if.sv - memory, execute and register-strobe bundle for the fetch sequencer
//
// Purpose: groups the sequencer's memory handshake, execute-stage requests and
// the MAR/IR load strobes and buses.
// Signals:
//   MemReady, MemData                    memory read response
//   ExecDone, Branch, BranchAddr, Halt   execute-stage completion / requests
//   MAR_LD, MAR_DIn                      active-low MAR load strobe and address
//   MemRd                                active-low memory read request
//   IR_LD, IR_DIn                        active-low IR load strobe and word
//   PC, Halted, Fault                    status
// Modports: master = the sequencer, slave = memory/execute/register side.

interface a09_fetch_sequencer_if #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8
);
    logic                 MemReady;
    logic [DataWidth-1:0] MemData;
    logic                 ExecDone;
    logic                 Branch;
    logic [AddrWidth-1:0] BranchAddr;
    logic                 Halt;
    logic                 MAR_LD;
    logic [AddrWidth-1:0] MAR_DIn;
    logic                 MemRd;
    logic                 IR_LD;
    logic [DataWidth-1:0] IR_DIn;
    logic [AddrWidth-1:0] PC;
    logic                 Halted;
    logic                 Fault;

    modport master (
        input  MemReady, MemData, ExecDone, Branch, BranchAddr, Halt,
        output MAR_LD, MAR_DIn, MemRd, IR_LD, IR_DIn, PC, Halted, Fault
    );

    modport slave (
        output MemReady, MemData, ExecDone, Branch, BranchAddr, Halt,
        input  MAR_LD, MAR_DIn, MemRd, IR_LD, IR_DIn, PC, Halted, Fault
    );
endinterface

// File: rtl/a09_program_counter.sv
// rtl/a09_program_counter.sv - program counter register with load and increment
//
// Purpose: holds the PC. Load has priority over increment; increment wraps
// modulo 2^AddrWidth.
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous, active-low; PC <= ResetVector
//   inc_en     in   PC <= PC + 1
//   load_en    in   PC <= load_addr (wins over inc_en)
//   load_addr  in   branch target
//   pc         out  current program counter

module a09_program_counter #(
    parameter int AddrWidth   = 8,
    parameter int ResetVector = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 inc_en,
    input  logic                 load_en,
    input  logic [AddrWidth-1:0] load_addr,
    output logic [AddrWidth-1:0] pc
);

    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_addr;
        end else if (inc_en) begin
            pc_d = pc_q + AddrWidth'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q <= AddrWidth'(ResetVector);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/a09_fetch_sequencer.sv
// rtl/a09_fetch_sequencer.sv - A09 fetch cycle sequencer driving MAR/IR load strobes
//
// Purpose: runs FETCH -> MEMRD -> IRLD -> EXEC, with a bounded memory wait
// that sets a sticky Fault and halts on expiry. Branch/halt requests from the
// execute stage are taken only when qualified by ExecDone.
// Ports:
//   Clk    in      clock, rising edge
//   Reset  in      synchronous, active-low
//   bus    master  memory handshake, execute requests, MAR/IR strobes, status
// All outputs are decoded from registers only (Moore).

module a09_fetch_sequencer #(
    parameter int DataWidth   = 8,
    parameter int AddrWidth   = 8,
    parameter int ResetVector = 0,
    parameter int MemTimeout  = 15
) (
    input  logic                   Clk,
    input  logic                   Reset,
    a09_fetch_sequencer_if.master  bus
);

    import a09_defs::*;

    localparam int WcW = wait_cnt_width(MemTimeout);
    // Last wait value before expiry; only meaningful when MemTimeout != 0.
    localparam logic [WcW-1:0] WaitLast = WcW'(MemTimeout - 1);
    localparam bit TimeoutOn = (MemTimeout != 0);

    state_e               state_q;
    state_e               state_d;
    logic [WcW-1:0]       wait_cnt_q;
    logic [WcW-1:0]       wait_cnt_d;
    logic [DataWidth-1:0] ir_q;
    logic [DataWidth-1:0] ir_d;
    logic                 fault_q;
    logic                 fault_d;
    logic                 pc_inc;
    logic                 pc_load;
    logic [AddrWidth-1:0] pc;

    a09_program_counter #(
        .AddrWidth   (AddrWidth),
        .ResetVector (ResetVector)
    ) u_pc (
        .Clk       (Clk),
        .Reset     (Reset),
        .inc_en    (pc_inc),
        .load_en   (pc_load),
        .load_addr (bus.BranchAddr),
        .pc        (pc)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_RESET;
            wait_cnt_q <= '0;
            ir_q       <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ir_q       <= ir_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        // Counter idles at zero outside MEMRD, so every MEMRD entry starts fresh.
        wait_cnt_d = '0;
        ir_d       = ir_q;
        fault_d    = fault_q;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: state_d = S_MEMRD;
            S_MEMRD: begin
                // MemReady is checked first so it wins over a coincident expiry.
                if (bus.MemReady) begin
                    ir_d    = bus.MemData;
                    state_d = S_IRLD;
                end else if (TimeoutOn && (wait_cnt_q == WaitLast)) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WcW'(1);
                end
            end
            S_IRLD: begin
                pc_inc  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bus.ExecDone) begin
                    pc_load = bus.Branch;
                    state_d = bus.Halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    assign bus.MAR_LD  = (state_q == S_FETCH) ? LD_ACTIVE : LD_IDLE;
    assign bus.MemRd   = (state_q == S_MEMRD) ? LD_ACTIVE : LD_IDLE;
    assign bus.IR_LD   = (state_q == S_IRLD)  ? LD_ACTIVE : LD_IDLE;
    assign bus.MAR_DIn = pc;
    assign bus.PC      = pc;
    assign bus.IR_DIn  = ir_q;
    assign bus.Halted  = (state_q == S_HALT);
    assign bus.Fault   = fault_q;

endmodule

// File: tb/tb_a09_fetch_sequencer.sv
// tb/tb_a09_fetch_sequencer.sv - directed vector bench for a09_fetch_sequencer

module tb_a09_fetch_sequencer;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [7:0] md;
        logic       ed;
        logic       br;
        logic [7:0] ba;
        logic       hl;
    } in_t;

    typedef struct packed {
        logic       mar_ld;
        logic [7:0] mar_din;
        logic       mem_rd;
        logic       ir_ld;
        logic [7:0] ir_din;
        logic [7:0] pc;
        logic       halted;
        logic       fault;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    a09_fetch_sequencer_if #(.DataWidth(8), .AddrWidth(8)) bus ();

    a09_fetch_sequencer #(
        .DataWidth   (8),
        .AddrWidth   (8),
        .ResetVector (8'h10),
        .MemTimeout  (15)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t vi(input logic rst, input logic mr, input logic [7:0] md,
                               input logic ed, input logic br, input logic [7:0] ba,
                               input logic hl);
        in_t r;
        r.rst = rst; r.mr = mr; r.md = md; r.ed = ed; r.br = br; r.ba = ba; r.hl = hl;
        return r;
    endfunction

    function automatic out_t vo(input logic mar_ld, input logic mem_rd, input logic ir_ld,
                                input logic [7:0] ir_din, input logic [7:0] pc,
                                input logic halted, input logic fault);
        out_t r;
        r.mar_ld = mar_ld; r.mar_din = pc; r.mem_rd = mem_rd; r.ir_ld = ir_ld;
        r.ir_din = ir_din; r.pc = pc; r.halted = halted; r.fault = fault;
        return r;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    // Drive at negedge, let one rising edge act, sample 1ns later.
    task automatic step(input string name, input in_t i, input out_t e);
        out_t a;
        int   lows;
        @(negedge clk);
        reset          = i.rst;
        bus.MemReady   = i.mr;
        bus.MemData    = i.md;
        bus.ExecDone   = i.ed;
        bus.Branch     = i.br;
        bus.BranchAddr = i.ba;
        bus.Halt       = i.hl;
        @(posedge clk);
        #1;
        a = {bus.MAR_LD, bus.MAR_DIn, bus.MemRd, bus.IR_LD, bus.IR_DIn, bus.PC,
             bus.Halted, bus.Fault};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got mar_ld=%b mar_din=%h mem_rd=%b ir_ld=%b ir_din=%h pc=%h halted=%b fault=%b want mar_ld=%b mar_din=%h mem_rd=%b ir_ld=%b ir_din=%h pc=%h halted=%b fault=%b",
                     name, a.mar_ld, a.mar_din, a.mem_rd, a.ir_ld, a.ir_din, a.pc, a.halted, a.fault,
                     e.mar_ld, e.mar_din, e.mem_rd, e.ir_ld, e.ir_din, e.pc, e.halted, e.fault);
        end
        lows = int'(!a.mar_ld) + int'(!a.mem_rd) + int'(!a.ir_ld);
        checks++;
        if (lows > 1) begin
            errors++;
            $display("FAIL %s strobe_excl: got %0d strobes low, want at most 1", name, lows);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.MemReady = 1'b0;
        bus.MemData = 8'h00;
        bus.ExecDone = 1'b0;
        bus.Branch = 1'b0;
        bus.BranchAddr = 8'h00;
        bus.Halt = 1'b0;

        // Reset held 3 cycles, release, first fetch at 8'h10.
        for (int k = 0; k < 3; k++) add(vi(0,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h00,8'h10,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(0,1,1,8'h00,8'h10,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h00,8'h10,0,0));
        add(vi(1,1,8'hA5,0,0,8'h00,0), vo(1,1,0,8'hA5,8'h10,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'hA5,8'h11,0,0));
        add(vi(1,0,8'h00,1,0,8'h00,0), vo(0,1,1,8'hA5,8'h11,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'hA5,8'h11,0,0));
        // MemReady delayed five cycles: MemRd low for six.
        for (int k = 0; k < 5; k++) add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'hA5,8'h11,0,0));
        add(vi(1,1,8'h3C,0,0,8'h00,0), vo(1,1,0,8'h3C,8'h11,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h3C,8'h12,0,0));
        // Branch/Halt without ExecDone are ignored.
        add(vi(1,0,8'h00,0,1,8'h77,1), vo(1,1,1,8'h3C,8'h12,0,0));
        add(vi(1,0,8'h00,1,1,8'hFF,0), vo(0,1,1,8'h3C,8'hFF,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h3C,8'hFF,0,0));
        add(vi(1,1,8'h5A,0,0,8'h00,0), vo(1,1,0,8'h5A,8'hFF,0,0));
        // PC wraps FF -> 00.
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h5A,8'h00,0,0));
        // Branch + Halt together: PC takes target and HALT is entered.
        add(vi(1,0,8'h00,1,1,8'h40,1), vo(1,1,1,8'h5A,8'h40,1,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h5A,8'h40,1,0));
        add(vi(1,1,8'h11,1,1,8'h99,0), vo(1,1,1,8'h5A,8'h40,1,0));
        // Reset out of HALT, then reset mid-MEMRD.
        add(vi(0,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h00,8'h10,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(0,1,1,8'h00,8'h10,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h00,8'h10,0,0));
        add(vi(0,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h00,8'h10,0,0));
        add(vi(1,0,8'h00,0,0,8'h00,0), vo(0,1,1,8'h00,8'h10,0,0));

        foreach (vecs[n]) begin
            step($sformatf("vec%0d", n), vecs[n].i, vecs[n].o);
        end

        // Timeout: MemReady never comes; 15 MEMRD cycles then Fault + HALT.
        step("to_enter", vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h00,8'h10,0,0));
        for (int k = 0; k < 14; k++) begin
            step($sformatf("to_wait%0d", k), vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h00,8'h10,0,0));
        end
        step("to_expire", vi(1,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h00,8'h10,1,1));
        for (int k = 0; k < 3; k++) begin
            step($sformatf("to_sticky%0d", k), vi(1,1,8'hEE,1,1,8'h22,0), vo(1,1,1,8'h00,8'h10,1,1));
        end
        step("to_reset", vi(0,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'h00,8'h10,0,0));

        // MemReady on the 15th MEMRD cycle, coinciding with expiry: accepted.
        step("edge_fetch", vi(1,0,8'h00,0,0,8'h00,0), vo(0,1,1,8'h00,8'h10,0,0));
        step("edge_memrd", vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h00,8'h10,0,0));
        for (int k = 0; k < 14; k++) begin
            step($sformatf("edge_wait%0d", k), vi(1,0,8'h00,0,0,8'h00,0), vo(1,0,1,8'h00,8'h10,0,0));
        end
        step("edge_accept", vi(1,1,8'hC3,0,0,8'h00,0), vo(1,1,0,8'hC3,8'h10,0,0));
        step("edge_exec", vi(1,0,8'h00,0,0,8'h00,0), vo(1,1,1,8'hC3,8'h11,0,0));
        step("edge_next", vi(1,0,8'h00,1,0,8'h00,0), vo(0,1,1,8'hC3,8'h11,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
